bin_to_bcd_seq: RTL and testbench

Parametrised, iterative binary-to-BCD converter using shift-and-add-3 (double dabble): one bit per clock, start/valid handshake. It succeeds the fixed 6-bit combinational binary-to-decimal converter with configurable input width and digit count, overflow detection and a held result register. It sits between arithmetic datapaths and display/report logic, for example 7-segment drivers and testbench decimal printing.

---
 rtl/bin_to_bcd_pkg.sv | 30 +++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 101 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // ceil(width * log10(2)), with log10(2) approximated as 0.30103.
  function automatic int unsigned digits_needed(input int unsigned width);
    int unsigned scaled;
    int unsigned d;
    scaled = width * 30103;
    d = 0;
    for (int unsigned i = 0; i <= width; i++) begin
      if (d * 100000 < scaled) d = d + 1;
    end
    return d;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DEF_WIDTH  = 6;
  localparam int unsigned DEF_DIGITS = 2;
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_WIDTH + 1);

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) d_o = d_i + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one operand bit per
// clock, with start/valid handshake, sticky overflow and held result.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  bcd_state_t          state_q;
  logic [CW-1:0]       cnt_q;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic [4*DIGITS-1:0] dig_q, dig_adj, dig_d;
  logic [4*DIGITS-1:0] bcd_q;
  logic                sticky_q, sticky_d;
  logic                ovf_bit;
  logic                busy_q, valid_q, overflow_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (dig_q[4*g +: 4]),
      .d_o (dig_adj[4*g +: 4])
    );
  end

  // The bit leaving the top digit is the one that cannot be represented.
  always_comb begin
    ovf_bit  = 1'b0;
    dig_d    = '0;
    opnd_d   = '0;
    {ovf_bit, dig_d, opnd_d} = {dig_adj, opnd_q, 1'b0};
    sticky_d = sticky_q | ovf_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opnd_q     <= '0;
      dig_q      <= '0;
      sticky_q   <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          valid_q <= 1'b0;
          if (start) begin
            state_q  <= SHIFT;
            busy_q   <= 1'b1;
            opnd_q   <= binary;
            dig_q    <= '0;
            cnt_q    <= CNT_INIT;
            sticky_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          dig_q    <= dig_d;
          opnd_q   <= opnd_d;
          sticky_q <= sticky_d;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            valid_q    <= 1'b1;
            bcd_q      <= dig_d;
            overflow_q <= sticky_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: three converter configurations against a countdown /
// decimal-arithmetic reference model, plus literal spot checks.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int unsigned W_of [3] = '{6, 8, 16};
  int unsigned D_of [3] = '{2, 2, 5};

  logic        start_v [3];
  logic [15:0] bin_v   [3];
  logic        busy_v  [3];
  logic        valid_v [3];
  logic        ovf_v   [3];
  logic [19:0] bcd_v   [3];

  logic [5:0]  bin0;
  logic [7:0]  bin1;
  logic [15:0] bin2;
  logic        busy0, busy1, busy2, valid0, valid1, valid2, ovf0, ovf1, ovf2;
  logic [7:0]  bcd0, bcd1;
  logic [19:0] bcd2;

  assign bin0 = bin_v[0][5:0];
  assign bin1 = bin_v[1][7:0];
  assign bin2 = bin_v[2];

  always_comb begin
    busy_v[0] = busy0;  busy_v[1] = busy1;  busy_v[2] = busy2;
    valid_v[0] = valid0; valid_v[1] = valid1; valid_v[2] = valid2;
    ovf_v[0] = ovf0;    ovf_v[1] = ovf1;    ovf_v[2] = ovf2;
    bcd_v[0] = {12'b0, bcd0};
    bcd_v[1] = {12'b0, bcd1};
    bcd_v[2] = bcd2;
  end

  bin_to_bcd_seq #(.WIDTH(6), .DIGITS(2)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .binary(bin0),
    .busy(busy0), .valid(valid0), .bcd(bcd0), .overflow(ovf0));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .binary(bin1),
    .busy(busy1), .valid(valid1), .bcd(bcd1), .overflow(ovf1));
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .binary(bin2),
    .busy(busy2), .valid(valid2), .bcd(bcd2), .overflow(ovf2));

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
  endtask

  function automatic logic [19:0] to_bcd(input longint v, input int unsigned d);
    logic [19:0] r;
    longint x;
    r = '0;
    x = v;
    for (int unsigned j = 0; j < d; j++) begin
      r[4*j +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic longint pow10(input int unsigned d);
    longint p;
    p = 1;
    for (int unsigned j = 0; j < d; j++) p = p * 10;
    return p;
  endfunction

  // Reference model: a conversion is a countdown of WIDTH cycles, then the
  // result is plain decimal arithmetic on the captured operand.
  int          left [3] = '{0, 0, 0};
  bit          mv   [3] = '{0, 0, 0};
  logic [19:0] eb   [3] = '{0, 0, 0};
  bit          eo   [3] = '{0, 0, 0};
  longint      op   [3] = '{0, 0, 0};
  bit          started = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        left[k] = 0; mv[k] = 0; eb[k] = '0; eo[k] = 0;
      end else if (left[k] > 0) begin
        left[k] = left[k] - 1;
        if (left[k] == 0) begin
          mv[k] = 1;
          eb[k] = to_bcd(op[k], D_of[k]);
          eo[k] = (op[k] >= pow10(D_of[k]));
        end
      end else begin
        mv[k] = 0;
        if (start_v[k]) begin
          op[k]   = longint'(bin_v[k]) % (longint'(1) << W_of[k]);
          left[k] = int'(W_of[k]);
        end
      end
    end
    if (reset) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        bit ok;
        ok = 1'b1;
        for (int unsigned j = 0; j < D_of[k]; j++)
          if (bcd_v[k][4*j +: 4] > 4'd9) ok = 1'b0;
        chk("busy", k, longint'(busy_v[k]), longint'(left[k] > 0));
        chk("valid", k, longint'(valid_v[k]), longint'(mv[k]));
        chk("bcd", k, longint'(bcd_v[k]), longint'(eb[k]));
        chk("overflow", k, longint'(ovf_v[k]), longint'(eo[k]));
        chk("digit_range", k, longint'(ok), 1);
      end
    end
  end

  task automatic wait_valid(input int k, output int cnt, output int bsy);
    cnt = 1;
    bsy = 0;
    while (!valid_v[k] && cnt < 60) begin
      if (busy_v[k]) bsy++;
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic convert(input int k, input longint val, input longint exp_b, input bit exp_o);
    int cnt, bsy;
    start_v[k] = 1'b1;
    bin_v[k]   = 16'(val);
    @(negedge clk);
    start_v[k] = 1'b0;
    wait_valid(k, cnt, bsy);
    chk("latency", k, longint'(cnt - 1), longint'(W_of[k]));
    chk("busy_cycles", k, longint'(bsy), longint'(W_of[k]));
    chk("bcd_lit", k, longint'(bcd_v[k]), exp_b);
    chk("ovf_lit", k, longint'(ovf_v[k]), longint'(exp_o));
  endtask

  initial begin
    int cnt, bsy;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      bin_v[k]   = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_bcd", 0, longint'(bcd_v[0]), 0);
    chk("reset_busy", 0, longint'(busy_v[0]), 0);
    reset = 1'b0;
    @(negedge clk);

    convert(0, 55, 'h55, 1'b0);
    convert(0, 0, 'h00, 1'b0);
    convert(0, 63, 'h63, 1'b0);
    for (int v = 0; v < 64; v++) convert(0, v, longint'(to_bcd(v, 2)), 1'b0);

    convert(1, 255, 'h55, 1'b1);
    convert(1, 99, 'h99, 1'b0);
    convert(2, 65535, 'h65535, 1'b0);

    // start re-pulsed mid-conversion must be ignored
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1; bin_v[0] = 16'd55;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1; bin_v[0] = 16'd12;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_valid(0, cnt, bsy);
    chk("ignored_start_bcd", 0, longint'(bcd_v[0]), 'h55);
    convert(0, 12, 'h12, 1'b0);

    // reset three cycles into a conversion
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1; bin_v[0] = 16'd37;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 0, longint'(busy_v[0]), 0);
    chk("rst_valid", 0, longint'(valid_v[0]), 0);
    chk("rst_bcd", 0, longint'(bcd_v[0]), 0);
    chk("rst_ovf", 0, longint'(ovf_v[0]), 0);
    repeat (10) @(negedge clk);
    convert(0, 42, 'h42, 1'b0);

    // randomized traffic on all three converters
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < 3; k++) begin
        start_v[k] = ($urandom_range(0, 2) == 0);
        bin_v[k]   = 16'($urandom);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
    repeat (25) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d passed expected %0d", passed, total);
    $fatal(1);
  end

endmodule
